mpalu_seq: RTL and testbench
============================

Name: mpalu_seq

Overview:
- Multi-precision arithmetic sequencer. Performs WORDS×16-bit MOV / NEG / ADD / SUB by time-multiplexing one 16-bit add/sub/mov/neg datapath (addsubmovneg16a), least-significant word first.
- Carry is chained between words through a register.
- Used by DSP control logic for wide accumulator and phase arithmetic where a full-width adder costs too much area.

Parameters:
- WORDS, 4, number of 16-bit words per operand. Legal values are 2..16; total width W = 16*WORDS.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RST_N  in  1  synchronous active-low reset.
- START  in  1  request a new operation; sampled only when not BUSY.
- OP  in  2  operation: 00 MOV (Y=B), 01 NEG (Y=~B+1), 10 ADD (Y=A+B), 11 SUB (Y=A+~B+1).
- A  in  W  operand A; latched on accepted START.
- B  in  W  operand B; latched on accepted START.
- BUSY  out  1  operation in progress.
- DONE  out  1  one-cycle pulse: Y/CO/OVF valid.
- Y  out  W  result register.
- CO  out  1  carry out of MSW (SUB/NEG: 1 = no borrow).
- OVF  out  1  two's-complement signed overflow of full-width result.

Behaviour:
- Reset (RST_N=0 at clock edge): state IDLE; BUSY=0, DONE=0, Y=0, CO=0, OVF=0; word index=0; carry register=0. Applies mid-operation: the operation is aborted, no DONE, and Y is cleared.
- States: IDLE, RUN.
- IDLE, START=1: latch A, B and OP; set idx=0; BUSY<=1; go to RUN. START=0: stay.
- RUN, each cycle, one word operation:
  - Datapath inputs are A_lat[idx], B_lat[idx]; ENA=OP[1], SUB=OP[0].
  - CI = OP[0] when idx=0, otherwise the carry register.
  - Y[idx] <= datapath Y; carry register <= datapath CO; idx <= idx+1.
- RUN, idx=WORDS-1 (last word), same edge:
  - CO <= datapath CO.
  - OVF <= (a_msb==b_msb) && (y_msb!=a_msb), where a_msb = OP[1] ? A_lat MSB : 0, b_msb = B_lat MSB ^ OP[0], and y_msb = result MSB.
  - DONE <= 1; BUSY <= 0; go to IDLE.
- DONE is high exactly one cycle and otherwise 0.
- Latency: START accepted at edge k. BUSY is high in cycles k+1..k+WORDS. DONE is high in cycle k+WORDS+1, where BUSY=0.
- Throughput: one operation per WORDS+1 cycles. START asserted in the DONE cycle is accepted; this is back-to-back operation.
- START while BUSY is ignored, not queued. A/B/OP changes while BUSY have no effect.
- Y words update progressively during RUN. Y is defined only when DONE=1 or in IDLE after DONE. Y, CO and OVF hold their values until the next accepted START modifies them.
- MOV: CO=0 unless carry arises (it cannot, since CI=0, so CO=0). OVF=0.
- NEG of 0: CO=1, OVF=0.
- NEG of the most negative value: Y equals the input, OVF=1.
- Arithmetic is modulo 2^W; no saturation.

Decomposition:
- Shared package mpalu_pkg:
  - OP encodings: OP_MOV=2'b00, OP_NEG=2'b01, OP_ADD=2'b10, OP_SUB=2'b11.
  - State encoding: IDLE, RUN.
  - Function clog2 for idx width.
- Sub-module: one instance of addsubmovneg16a (16-bit add/sub/mov/neg datapath). No other sub-modules are needed. Word selection muxes and the Y write decode are in mpalu_seq.

Test Plan:
- WORDS=4, ADD A=0x0000_0000_0000_FFFF, B=0x1 → DONE at cycle k+5, Y=0x0000_0000_0001_0000, CO=0, OVF=0. BUSY is high exactly 4 cycles.
- SUB A=0, B=1 → Y=0xFFFF_FFFF_FFFF_FFFF, CO=0 (borrow), OVF=0. Then SUB A=5, B=5 → Y=0, CO=1.
- NEG B=0x8000_0000_0000_0000 → Y=0x8000_0000_0000_0000, OVF=1. NEG B=0 → Y=0, CO=1, OVF=0. MOV B=0x1234_5678_9ABC_DEF0 → Y=B, CO=0, OVF=0.
- ADD A=0x7FFF_FFFF_FFFF_FFFF, B=1 → Y=0x8000_0000_0000_0000, OVF=1, CO=0. START held high during BUSY with different A/B → ignored; result unchanged.
- Back-to-back: second START in the DONE cycle → accepted. Second DONE occurs exactly 5 cycles after the first. Both results are correct.
- RST_N=0 for one cycle at idx=2 of an ADD → next cycle BUSY=0, Y=0, CO=0, OVF=0, and no DONE pulse follows. A subsequent operation completes correctly.

Source files
------------

// File: rtl/mpalu_pkg.sv
// Shared definitions for the multi-precision ALU sequencer: opcodes, FSM states, index sizing.
package mpalu_pkg;

    typedef enum logic [1:0] {
        OP_MOV = 2'b00,
        OP_NEG = 2'b01,
        OP_ADD = 2'b10,
        OP_SUB = 2'b11
    } op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Width needed to index n words; never below 1 bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mpalu_seq_addsubmovneg16a.sv
// 16-bit add/sub/mov/neg slice: y = (ena ? a : 0) + (sub ? ~b : b) + ci.
// Purely combinational; carry in/out let the sequencer chain words.
module addsubmovneg16a (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        ci,
    input  logic        ena,
    input  logic        sub,
    output logic [15:0] y,
    output logic        co
);

    logic [15:0] a_eff;
    logic [15:0] b_eff;

    always_comb begin
        a_eff   = ena ? a : 16'h0000;
        b_eff   = sub ? ~b : b;
        {co, y} = {1'b0, a_eff} + {1'b0, b_eff} + {16'h0000, ci};
    end

endmodule

// File: rtl/mpalu_seq.sv
// WORDS x 16-bit MOV/NEG/ADD/SUB sequencer, one word per cycle, LSW first, through a single 16-bit slice.
// Result, carry and overflow are flagged by a one-cycle DONE pulse WORDS+1 cycles after START is accepted.
module mpalu_seq
    import mpalu_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  START,
    input  logic [1:0]            OP,
    input  logic [16*WORDS-1:0]   A,
    input  logic [16*WORDS-1:0]   B,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [16*WORDS-1:0]   Y,
    output logic                  CO,
    output logic                  OVF
);

    localparam int W  = 16 * WORDS;
    localparam int IW = clog2(WORDS);
    localparam logic [IW-1:0] IDX_LAST = IW'(WORDS - 1);

    state_e          state_q;
    state_e          state_d;
    logic [IW-1:0]   idx_q;
    logic            carry_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [1:0]      op_q;
    logic [W-1:0]    y_q;
    logic            co_q;
    logic            ovf_q;
    logic            done_q;

    logic            accept;
    logic            last;
    logic [IW+3:0]   word_base;
    logic [15:0]     dp_a;
    logic [15:0]     dp_b;
    logic            dp_ci;
    logic [15:0]     dp_y;
    logic            dp_co;
    logic            a_msb;
    logic            b_msb;
    logic            ovf_d;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (idx_q == IDX_LAST) begin
                    last    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        word_base = {idx_q, 4'b0000};
        dp_a      = a_q[word_base +: 16];
        dp_b      = b_q[word_base +: 16];
        // The first word takes the +1 of the two's-complement negate as its carry in.
        dp_ci     = (idx_q == '0) ? op_q[0] : carry_q;
        a_msb     = op_q[1] & a_q[W-1];
        b_msb     = b_q[W-1] ^ op_q[0];
        ovf_d     = (a_msb == b_msb) && (dp_y[15] != a_msb);
    end

    addsubmovneg16a u_dp (
        .a   (dp_a),
        .b   (dp_b),
        .ci  (dp_ci),
        .ena (op_q[1]),
        .sub (op_q[0]),
        .y   (dp_y),
        .co  (dp_co)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 2'b00;
            y_q     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= last;
            if (accept) begin
                a_q   <= A;
                b_q   <= B;
                op_q  <= OP;
                idx_q <= '0;
            end
            if (state_q == RUN) begin
                y_q[word_base +: 16] <= dp_y;
                carry_q              <= dp_co;
                idx_q                <= idx_q + IW'(1);
            end
            if (last) begin
                co_q  <= dp_co;
                ovf_q <= ovf_d;
            end
        end
    end

    assign BUSY = (state_q == RUN);
    assign DONE = done_q;
    assign Y    = y_q;
    assign CO   = co_q;
    assign OVF  = ovf_q;

endmodule

// File: tb/tb_mpalu_seq.sv
// Directed bench for mpalu_seq with WORDS=4: latency, arithmetic corners, ignored START, back-to-back, mid-op reset.
module tb_mpalu_seq;
    import mpalu_pkg::*;

    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         CLK;
    logic         RST_N;
    logic         START;
    logic [1:0]   OP;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         BUSY;
    logic         DONE;
    logic [W-1:0] Y;
    logic         CO;
    logic         OVF;

    int errors = 0;
    int checks = 0;

    mpalu_seq #(.WORDS(WORDS)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .OP    (OP),
        .A     (A),
        .B     (B),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .Y     (Y),
        .CO    (CO),
        .OVF   (OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Starts an operation from the current cycle and returns in the DONE cycle.
    // lat counts cycles from the accepting edge to DONE (0 if DONE never came).
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit hold, output int lat, output int busy_cnt);
        START = 1'b1;
        OP    = op;
        A     = a;
        B     = b;
        @(posedge CLK); #1;
        if (hold) begin
            OP = ~op;
            A  = ~a;
            B  = ~b;
        end else begin
            START = 1'b0;
        end
        lat      = 0;
        busy_cnt = 0;
        for (int c = 1; c <= 20; c++) begin
            if (BUSY) busy_cnt++;
            if (DONE) begin
                lat = c;
                break;
            end
            @(posedge CLK); #1;
        end
        START = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        START = 1'b0;
        OP    = 2'b00;
        A     = '0;
        B     = '0;
        repeat (2) @(posedge CLK);
        #1;
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", DONE); end
        checks++; if (Y !== 64'h0) begin errors++; $display("FAIL reset_y: got %h want 0", Y); end
        checks++; if ({CO, OVF} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {CO, OVF}); end
        RST_N = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic test_add();
        int lat, bc;
        run_op(OP_ADD, 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, lat, bc);
        checks++; if (lat !== 5) begin errors++; $display("FAIL add_latency: got %0d want 5", lat); end
        checks++; if (bc !== 4) begin errors++; $display("FAIL add_busy_cycles: got %0d want 4", bc); end
        checks++; if (Y !== 64'h0000_0000_0001_0000) begin errors++; $display("FAIL add_y: got %h want 0000000000010000", Y); end
        checks++; if ({CO, OVF} !== 2'b00) begin errors++; $display("FAIL add_flags: got %b want 00", {CO, OVF}); end
        @(posedge CLK); #1;
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL add_done_pulse: got %b want 0", DONE); end
        checks++; if (Y !== 64'h0000_0000_0001_0000) begin errors++; $display("FAIL add_y_hold: got %h want 0000000000010000", Y); end
    endtask

    task automatic test_sub();
        int lat, bc;
        run_op(OP_SUB, 64'h0, 64'h1, 1'b0, lat, bc);
        checks++; if (Y !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL sub_borrow_y: got %h want ffffffffffffffff", Y); end
        checks++; if ({CO, OVF} !== 2'b00) begin errors++; $display("FAIL sub_borrow_flags: got %b want 00", {CO, OVF}); end
        @(posedge CLK); #1;
        run_op(OP_SUB, 64'h5, 64'h5, 1'b0, lat, bc);
        checks++; if (Y !== 64'h0) begin errors++; $display("FAIL sub_equal_y: got %h want 0", Y); end
        checks++; if ({CO, OVF} !== 2'b10) begin errors++; $display("FAIL sub_equal_flags: got %b want 10", {CO, OVF}); end
        @(posedge CLK); #1;
    endtask

    task automatic test_neg_mov();
        int lat, bc;
        run_op(OP_NEG, 64'h0, 64'h8000_0000_0000_0000, 1'b0, lat, bc);
        checks++; if (Y !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL neg_min_y: got %h want 8000000000000000", Y); end
        checks++; if ({CO, OVF} !== 2'b01) begin errors++; $display("FAIL neg_min_flags: got %b want 01", {CO, OVF}); end
        @(posedge CLK); #1;
        run_op(OP_NEG, 64'hFFFF_0000_1234_0000, 64'h0, 1'b0, lat, bc);
        checks++; if (Y !== 64'h0) begin errors++; $display("FAIL neg_zero_y: got %h want 0", Y); end
        checks++; if ({CO, OVF} !== 2'b10) begin errors++; $display("FAIL neg_zero_flags: got %b want 10", {CO, OVF}); end
        @(posedge CLK); #1;
        run_op(OP_MOV, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234_5678_9ABC_DEF0, 1'b0, lat, bc);
        checks++; if (Y !== 64'h1234_5678_9ABC_DEF0) begin errors++; $display("FAIL mov_y: got %h want 123456789abcdef0", Y); end
        checks++; if ({CO, OVF} !== 2'b00) begin errors++; $display("FAIL mov_flags: got %b want 00", {CO, OVF}); end
        @(posedge CLK); #1;
    endtask

    task automatic test_ovf_hold();
        int lat, bc;
        run_op(OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, lat, bc);
        checks++; if (lat !== 5) begin errors++; $display("FAIL hold_latency: got %0d want 5", lat); end
        checks++; if (Y !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL add_ovf_y: got %h want 8000000000000000", Y); end
        checks++; if ({CO, OVF} !== 2'b01) begin errors++; $display("FAIL add_ovf_flags: got %b want 01", {CO, OVF}); end
        @(posedge CLK); #1;
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL hold_idle: got busy=%b want 0", BUSY); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        run_op(OP_ADD, 64'h1, 64'h2, 1'b0, lat, bc);
        checks++; if (Y !== 64'h3) begin errors++; $display("FAIL b2b_first_y: got %h want 3", Y); end
        run_op(OP_SUB, 64'hA, 64'h3, 1'b0, lat, bc);
        checks++; if (lat !== 5) begin errors++; $display("FAIL b2b_done_spacing: got %0d want 5", lat); end
        checks++; if (Y !== 64'h7) begin errors++; $display("FAIL b2b_second_y: got %h want 7", Y); end
        checks++; if ({CO, OVF} !== 2'b10) begin errors++; $display("FAIL b2b_second_flags: got %b want 10", {CO, OVF}); end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        bit seen;
        START = 1'b1;
        OP    = OP_ADD;
        A     = 64'h3;
        B     = 64'h4;
        @(posedge CLK); #1;
        START = 1'b0;
        repeat (2) begin
            @(posedge CLK); #1;
        end
        // Word 2 is being processed in this cycle.
        RST_N = 1'b0;
        @(posedge CLK); #1;
        RST_N = 1'b1;
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", BUSY); end
        checks++; if (Y !== 64'h0) begin errors++; $display("FAIL midrst_y: got %h want 0", Y); end
        checks++; if ({CO, OVF} !== 2'b00) begin errors++; $display("FAIL midrst_flags: got %b want 00", {CO, OVF}); end
        seen = 1'b0;
        repeat (8) begin
            if (DONE) seen = 1'b1;
            @(posedge CLK); #1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midrst_no_done: got %b want 0", seen); end
        run_op(OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat, bc);
        checks++; if (lat !== 5) begin errors++; $display("FAIL after_rst_latency: got %0d want 5", lat); end
        checks++; if (Y !== 64'h0) begin errors++; $display("FAIL after_rst_y: got %h want 0", Y); end
        checks++; if ({CO, OVF} !== 2'b10) begin errors++; $display("FAIL after_rst_flags: got %b want 10", {CO, OVF}); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_neg_mov();
        test_ovf_hold();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
